// File: rtl/memory.sv
//------------------------------------------------------------------------------
// memory: 512 x 32 word-addressed data memory for the MIPS MEM stage.
// Optional MEM_WRITE_FORWARD_EN: write-first forwarding on same-cycle read/write.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module memory #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  output logic [DATA_WIDTH-1:0] Read_Data
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] w_rdata;

  // Reset wipes the whole array and takes priority over any write on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (MemWrite) begin
      r_mem[MemAddr] <= Write_Data;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (rst_n && MemRead) begin
`ifdef MEM_WRITE_FORWARD_EN
      w_rdata = MemWrite ? Write_Data : r_mem[MemAddr];
`else
      w_rdata = r_mem[MemAddr];
`endif
    end
  end

  assign Read_Data = w_rdata;

endmodule

`default_nettype wire

// File: tb/tb_memory.sv
// Directed self-checking bench for memory.
`default_nettype none

module tb_memory;

  logic        clk;
  logic        rst_n;
  logic [8:0]  MemAddr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Write_Data;
  logic [31:0] Read_Data;

  int checks;
  int errors;

  memory #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemAddr    (MemAddr),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Write_Data (Write_Data),
    .Read_Data  (Read_Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [31:0] d);
    MemAddr = a; Write_Data = d; MemWrite = 1'b1; MemRead = 1'b0;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [8:0] a, input logic [31:0] exp);
    MemAddr = a; MemRead = 1'b1; MemWrite = 1'b0;
    #1;
    checks++;
    if (Read_Data !== exp) begin
      errors++;
      $display("FAIL %s addr=%h got=%h expected=%h", name, a, Read_Data, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; MemAddr = 9'h000; Write_Data = '0;
    #1;
    checks++;
    if (Read_Data !== 32'h0) begin
      errors++;
      $display("FAIL reset_comb_zero got=%h expected=%h", Read_Data, 32'h0);
    end
    tick();
    rst_n = 1'b1;
    read_chk("reset_000", 9'h000, 32'h0);
    read_chk("reset_1ff", 9'h1FF, 32'h0);
  endtask

  task automatic test_write_read();
    do_write(9'h000, 32'h0002C903);
    do_write(9'h001, 32'hFE923F55);
    do_write(9'h004, 32'h0FF00FF0);
    do_write(9'h008, 32'hFFFFFF00);
    read_chk("wr_000", 9'h000, 32'h0002C903);
    read_chk("wr_001", 9'h001, 32'hFE923F55);
    read_chk("wr_004", 9'h004, 32'h0FF00FF0);
    read_chk("wr_008", 9'h008, 32'hFFFFFF00);
    read_chk("unwritten_00c", 9'h00C, 32'h0);
  endtask

  task automatic test_read_enable();
    MemAddr = 9'h001; MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    checks++;
    if (Read_Data !== 32'h0) begin
      errors++;
      $display("FAIL read_disabled got=%h expected=%h", Read_Data, 32'h0);
    end
    MemRead = 1'b1;
    #1;
    checks++;
    if (Read_Data !== 32'hFE923F55) begin
      errors++;
      $display("FAIL read_enable_comb got=%h expected=%h", Read_Data, 32'hFE923F55);
    end
    // Address change in the same cycle must be followed without a clock.
    MemAddr = 9'h008;
    #1;
    checks++;
    if (Read_Data !== 32'hFFFFFF00) begin
      errors++;
      $display("FAIL read_addr_follow got=%h expected=%h", Read_Data, 32'hFFFFFF00);
    end
  endtask

  task automatic test_collision();
    logic [31:0] exp_before;
`ifdef MEM_WRITE_FORWARD_EN
    exp_before = 32'h12345678;
`else
    exp_before = 32'h0FF00FF0;
`endif
    MemAddr = 9'h004; MemRead = 1'b1; MemWrite = 1'b1; Write_Data = 32'h12345678;
    #1;
    checks++;
    if (Read_Data !== exp_before) begin
      errors++;
      $display("FAIL collision_before got=%h expected=%h", Read_Data, exp_before);
    end
    tick();
    MemWrite = 1'b0;
    #1;
    checks++;
    if (Read_Data !== 32'h12345678) begin
      errors++;
      $display("FAIL collision_after got=%h expected=%h", Read_Data, 32'h12345678);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_write(9'h000, 32'hDEADBEEF);
    read_chk("overwrite_000", 9'h000, 32'hDEADBEEF);
    rst_n = 1'b0; MemWrite = 1'b1; MemRead = 1'b1; MemAddr = 9'h000; Write_Data = 32'hAAAAAAAA;
    tick();
    rst_n = 1'b1; MemWrite = 1'b0;
    read_chk("reset_mid_000", 9'h000, 32'h0);
    bad = 0;
    for (int a = 0; a < 512; a++) begin
      MemAddr = a[8:0];
      #1;
      if (Read_Data !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_all nonzero_words=%0d expected=0", bad);
    end
  endtask

  task automatic test_boundary();
    do_write(9'h000, 32'h11111111);
    do_write(9'h1FF, 32'hCAFEF00D);
    read_chk("boundary_1ff", 9'h1FF, 32'hCAFEF00D);
    read_chk("boundary_000", 9'h000, 32'h11111111);
    read_chk("boundary_1fe", 9'h1FE, 32'h0);
  endtask

  task automatic test_idle();
    MemAddr = 9'h1FF; MemRead = 1'b0; MemWrite = 1'b0; Write_Data = 32'h55555555;
    tick();
    read_chk("idle_unchanged", 9'h1FF, 32'hCAFEF00D);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1; MemAddr = '0; MemRead = 1'b0; MemWrite = 1'b0; Write_Data = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_read_enable();
    test_collision();
    test_reset_mid();
    test_boundary();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
